// File: rtl/intr_pkg.sv
// Shared constants for the interrupt controller: FSM state encoding,
// register addresses and STAT register bit positions.
package intr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_EDGE = 2'd1;
  localparam logic [1:0] ADDR_PEND = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd3;

  localparam int STAT_INSVC_BIT  = 9;
  localparam int STAT_STATE_MSB  = 8;
  localparam int STAT_STATE_LSB  = 7;

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-first priority encoder; bit 0 has the highest priority.
module intr_prio_enc #(
  parameter int N_SRC = 8,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    id    = {ID_W{1'b0}};
    valid = |req;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      id = req[i] ? ID_W'(i) : id;
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: mask, edge/level pending, priority pick, ack/EOI FSM.
// Optional INTR_CTRL_SYNC_EN adds a 2-flop synchronizer on every src line.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SRC-1:0]  src,
  input  logic              ack,
  input  logic              eoi,
  output logic              interrupt,
  output logic [ID_W-1:0]   irq_id,
  input  logic              reg_we,
  input  logic [1:0]        reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata
);

  logic [N_SRC-1:0] src_s, src_prev_r, mask_r, edge_r, pend_r, pend_n_s;
  logic [N_SRC-1:0] wdat_s, set_s, clr_s, ack_vec_s, elig_s;
  logic             wr_mask_s, wr_edge_s, wr_pend_s, ack_take_s;
  logic             win_vld_s, interrupt_r, interrupt_n_s;
  logic [ID_W-1:0]  win_id_s, irq_id_r, irq_id_n_s;
  state_t           state_r, state_n_s;
  logic             unused_s;

`ifdef INTR_CTRL_SYNC_EN
  logic [N_SRC-1:0] sync1_r, sync2_r;

  // Two-stage synchronizer for asynchronous peripheral lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= {N_SRC{1'b0}};
      sync2_r <= {N_SRC{1'b0}};
    end else begin
      sync1_r <= src;
      sync2_r <= sync1_r;
    end
  end
  assign src_s = sync2_r;
`else
  assign src_s = src;
`endif

  assign unused_s   = ^reg_wdata;
  assign wdat_s     = reg_wdata[N_SRC-1:0];
  assign wr_mask_s  = reg_we && (reg_addr == ADDR_MASK);
  assign wr_edge_s  = reg_we && (reg_addr == ADDR_EDGE);
  assign wr_pend_s  = reg_we && (reg_addr == ADDR_PEND);
  assign ack_take_s = (state_r == REQ) && ack;

  // Edge bits: set beats clear; level bits simply follow src.
  assign set_s     = src_s & ~src_prev_r;
  assign ack_vec_s = ack_take_s ? ({{(N_SRC-1){1'b0}}, 1'b1} << irq_id_r) : {N_SRC{1'b0}};
  assign clr_s     = (wr_pend_s ? wdat_s : {N_SRC{1'b0}}) | ack_vec_s;
  assign pend_n_s  = (edge_r & (set_s | (pend_r & ~clr_s))) | (~edge_r & src_s);
  assign elig_s    = pend_r & mask_r;

  intr_prio_enc #(.N_SRC(N_SRC), .ID_W(ID_W)) u_enc (
    .req   (elig_s),
    .valid (win_vld_s),
    .id    (win_id_s)
  );

  // Configuration registers, pending bits and edge-detect history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_r     <= {N_SRC{1'b0}};
      edge_r     <= {N_SRC{1'b0}};
      pend_r     <= {N_SRC{1'b0}};
      src_prev_r <= {N_SRC{1'b0}};
    end else begin
      mask_r     <= wr_mask_s ? wdat_s : mask_r;
      edge_r     <= wr_edge_s ? wdat_s : edge_r;
      pend_r     <= pend_n_s;
      src_prev_r <= src_s;
    end
  end

  // Request FSM: next state and the registered request/ID values.
  always_comb begin
    state_n_s     = state_r;
    interrupt_n_s = 1'b0;
    irq_id_n_s    = irq_id_r;
    case (state_r)
      IDLE: begin
        if (win_vld_s) begin
          state_n_s     = REQ;
          interrupt_n_s = 1'b1;
          irq_id_n_s    = win_id_s;
        end else begin
          state_n_s     = IDLE;
        end
      end
      REQ: begin
        if (ack) begin
          state_n_s     = SVC;
        end else if (!elig_s[irq_id_r]) begin
          state_n_s     = IDLE;
        end else begin
          interrupt_n_s = 1'b1;
        end
      end
      SVC: begin
        if (eoi) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = SVC;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // FSM state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      interrupt_r <= 1'b0;
      irq_id_r    <= {ID_W{1'b0}};
    end else begin
      state_r     <= state_n_s;
      interrupt_r <= interrupt_n_s;
      irq_id_r    <= irq_id_n_s;
    end
  end

  assign interrupt = interrupt_r;
  assign irq_id    = irq_id_r;

  // Register read mux; bits above N_SRC read as zero.
  always_comb begin
    reg_rdata = 32'd0;
    case (reg_addr)
      ADDR_MASK: reg_rdata = 32'(mask_r);
      ADDR_EDGE: reg_rdata = 32'(edge_r);
      ADDR_PEND: reg_rdata = 32'(pend_r);
      ADDR_STAT: begin
        reg_rdata[STAT_INSVC_BIT]                = (state_r == SVC);
        reg_rdata[STAT_STATE_MSB:STAT_STATE_LSB] = state_r;
        reg_rdata[ID_W-1:0]                      = irq_id_r;
      end
      default: reg_rdata = 32'd0;
    endcase
  end

endmodule
